// File: rtl/fetch_unit_pkg.sv
// Shared widths, default halt encoding, FSM states and the instruction-register record.
package fetch_unit_pkg;
  localparam int ADDR_W  = 12;
  localparam int INSTR_W = 16;
  localparam logic [INSTR_W-1:0] HALT_WORD_DEF = 16'h0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } ir_t;
endpackage

// File: rtl/fetch_pc.sv
// Program counter: reset value, absolute load, and +1 that wraps at the top of the address space.
module fetch_pc
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 12'h000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);
  always_ff @(posedge clk) begin
    if (rst)       pc <= RESET_PC;
    else if (load) pc <= load_addr;
    else if (inc)  pc <= pc + 1'b1;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: one-entry instruction register with valid/ready handoff,
// redirect flush, and halt-word drain.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  RESET_PC  = 12'h000,
  parameter logic [INSTR_W-1:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [ADDR_W-1:0]  instr_addr,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [INSTR_W-1:0] ir_out,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               halted,
  output logic [INSTR_W-1:0] instr_count
);
  state_t            state, state_n;
  ir_t               ir;
  logic [ADDR_W-1:0] pc, pc_load_addr;
  logic              pc_load, pc_inc, capture, flush, xfer;

  fetch_pc #(.RESET_PC(RESET_PC)) u_pc (
    .clk       (clk),
    .rst       (rst),
    .load      (pc_load),
    .load_addr (pc_load_addr),
    .inc       (pc_inc),
    .pc        (pc)
  );

  assign instr_addr = pc;
  assign ir_out     = ir.instr;
  assign ir_pc      = ir.pc;
  assign halted     = (state == S_HALT);
  assign xfer       = ir_valid && ir_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Redirect outranks both a capture and a transfer in the same cycle.
  always_comb begin
    state_n      = state;
    pc_load      = 1'b0;
    pc_load_addr = redirect_addr;
    pc_inc       = 1'b0;
    capture      = 1'b0;
    flush        = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        state_n      = S_RUN;
        pc_load      = 1'b1;
        pc_load_addr = RESET_PC;
      end
      S_RUN: begin
        if (redirect) begin
          pc_load = 1'b1;
          flush   = 1'b1;
        end else if (!ir_valid || ir_ready) begin
          capture = 1'b1;
          pc_inc  = 1'b1;
          if (instr_in == HALT_WORD) state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (redirect) begin
          state_n = S_RUN;
          pc_load = 1'b1;
          flush   = 1'b1;
        end else if (xfer) begin
          state_n = S_HALT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir       <= '0;
      ir_valid <= 1'b0;
    end else if (flush) begin
      ir_valid <= 1'b0;
    end else if (capture) begin
      ir.instr <= instr_in;
      ir.pc    <= pc;
      ir_valid <= 1'b1;
    end else if (xfer) begin
      ir_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      instr_count <= '0;
    else if (xfer && !flush && instr_count != {INSTR_W{1'b1}})
      instr_count <= instr_count + 1'b1;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 12'h000, address loaded into PC on start.
REQ-002 Parameter: HALT_WORD, default 16'h0000, instruction encoding that stops fetching.
REQ-003 Port: clk, input, 1, the only clock; all state updates on its rising edge.
REQ-004 Port: rst, input, 1, synchronous active-high reset.
REQ-005 Port: start, input, 1, one-cycle pulse that begins fetching from IDLE.
REQ-006 Port: instr_addr, output, 12, combinational fetch address to the instruction memory, equal to PC.
REQ-007 Port: instr_in, input, 16, instruction word returned combinationally by memory for instr_addr.
REQ-008 Port: ir_out, output, 16, registered instruction presented downstream.
REQ-009 Port: ir_pc, output, 12, address from which ir_out was fetched.
REQ-010 Port: ir_valid, output, 1, ir_out/ir_pc hold a live instruction.
REQ-011 Port: ir_ready, input, 1, downstream accepts ir_out this cycle.
REQ-012 Port: redirect, input, 1, jump/branch request that replaces PC and flushes ir_out.
REQ-013 Port: redirect_addr, input, 12, new PC when redirect is high.
REQ-014 Port: halted, output, 1, high in HALT state.
REQ-015 Port: instr_count, output, 16, count of instructions accepted downstream.

Function
REQ-016 States: IDLE, RUN, DRAIN, HALT; encoding is implementation-defined.
REQ-017 IDLE: no capture; start moves to RUN with PC=RESET_PC next cycle.
REQ-018 RUN: capture occurs when (!ir_valid || ir_ready) and !redirect; capture loads ir_out=instr_in, ir_pc=PC, ir_valid=1, PC=PC+1.
REQ-019 Throughput: one instruction per cycle while ir_ready stays high; fetch-to-ir_valid latency is one cycle.
REQ-020 Backpressure: while ir_valid && !ir_ready, ir_out, ir_pc and PC hold unchanged.
REQ-021 Handshake: a transfer occurs on any cycle with ir_valid && ir_ready; ir_valid drops next cycle unless a new capture occurs.
REQ-022 PC increment wraps 12'hFFF -> 12'h000 with no flag.
REQ-023 Halt: a captured word equal to HALT_WORD is delivered downstream normally; the FSM enters DRAIN and fetches nothing further.
REQ-024 DRAIN: enters HALT on the cycle the halt word transfers; halted asserts the following cycle.
REQ-025 HALT: no captures; ir_valid=0; only rst exits.
REQ-026 Redirect in RUN or DRAIN: next cycle PC=redirect_addr, ir_valid=0, state=RUN; redirect wins over a simultaneous capture or transfer, and the flushed word is not counted.
REQ-027 Redirect and start are ignored in HALT; start is ignored outside IDLE.
REQ-028 instr_count increments by 1 per transfer and saturates at 16'hFFFF.

Reset
REQ-029 rst high at a clock edge forces state=IDLE, PC=RESET_PC, ir_out=16'h0000, ir_pc=12'h000, ir_valid=0, halted=0 and instr_count=0, overriding all other inputs, including mid-fetch.

Structure
REQ-030 A shared package holds ADDR_W=12, INSTR_W=16, the default HALT_WORD and the state enumeration type.
REQ-031 One sub-module, fetch_pc, holds the PC register with load, increment and wrap; all other logic stays in fetch_unit.

Verification
REQ-032 Memory {0x2001, 0x2002, 0x2003, 0x0000}, start, ir_ready=1 -> ir_out 0x2001, 0x2002, 0x2003, 0x0000 on consecutive cycles with ir_pc 0..3; halted high two cycles after the 0x0000 capture; instr_count=4.
REQ-033 ir_ready=0 for 3 cycles after the first capture -> ir_out=0x2001 and ir_pc=0 stable; PC stays 1; no instruction is lost or duplicated after release.
REQ-034 redirect=1 with redirect_addr=12'h080 while ir_valid && ir_ready -> next cycle ir_valid=0 and instr_addr=0x080; instr_count does not count the flushed word.
REQ-035 redirect_addr=12'hFFF, no halt word -> ir_pc sequence 0xFFF, 0x000, 0x001.
REQ-036 rst asserted in RUN and in DRAIN -> all outputs at reset values next cycle; further start pulses are required to fetch again.
REQ-037 redirect and start pulsed in HALT -> no change; halted stays 1.
